// File: rtl/mem_store_wbuf_pkg.sv
// Shared op codes, stall encoding and write-buffer entry type
// for the MEM-stage store path.
package mem_store_wbuf_pkg;

   localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
   localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
   localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;
   localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

   localparam logic STOP   = 1'b1;
   localparam logic NOSTOP = 1'b0;

   typedef enum logic [2:0] {
      ST_NONE,
      ST_SB,
      ST_SH,
      ST_SW,
      ST_SWL,
      ST_SWR,
      ST_SC
   } st_kind_e;

   typedef struct packed {
      logic [29:0] waddr;
      logic [3:0]  sel;
      logic [31:0] data;
   } wbuf_entry_t;

   function automatic st_kind_e store_kind(input logic [7:0] op);
      st_kind_e k;
      k = ST_NONE;
      case (op)
         EXE_SB_OP:  k = ST_SB;
         EXE_SH_OP:  k = ST_SH;
         EXE_SW_OP:  k = ST_SW;
         EXE_SWL_OP: k = ST_SWL;
         EXE_SWR_OP: k = ST_SWR;
         EXE_SC_OP:  k = ST_SC;
         default:    k = ST_NONE;
      endcase
      return k;
   endfunction

   function automatic logic is_load(input logic [7:0] op);
      return op inside {EXE_LB_OP, EXE_LH_OP, EXE_LWL_OP, EXE_LW_OP,
                        EXE_LBU_OP, EXE_LHU_OP, EXE_LWR_OP, EXE_LL_OP};
   endfunction

endpackage

// File: rtl/mem_store_wbuf_store_lane_dec.sv
// Store lane decoder: big-endian byte selects, lane-shifted
// data and store address-error detect.
module store_lane_dec
   import mem_store_wbuf_pkg::*;
(
   input  logic [7:0]  op_i,
   input  logic [1:0]  a_i,
   input  logic [31:0] reg_i,
   output logic [3:0]  sel_o,
   output logic [31:0] data_o,
   output logic        ades_o
);

   st_kind_e   kind;
   logic [1:0] ra;

   assign kind = store_kind(op_i);
   assign ra   = 2'd3 - a_i;

   // per-flavour lane select, data placement and alignment fault
   always_comb begin
      sel_o  = 4'b0000;
      data_o = 32'h0;
      ades_o = 1'b0;
      unique case (kind)
         ST_SB: begin
            sel_o  = 4'b1000 >> a_i;
            data_o = {4{reg_i[7:0]}};
         end
         ST_SH: begin
            sel_o  = a_i[1] ? 4'b0011 : 4'b1100;
            data_o = {2{reg_i[15:0]}};
            ades_o = a_i[0];
         end
         ST_SW, ST_SC: begin
            sel_o  = 4'b1111;
            data_o = reg_i;
            ades_o = (a_i != 2'b00);
         end
         ST_SWL: begin
            sel_o  = 4'b1111 >> a_i;
            data_o = reg_i >> {a_i, 3'b000};
         end
         ST_SWR: begin
            sel_o  = 4'b1111 << ra;
            data_o = reg_i << {ra, 3'b000};
         end
         default: begin
            sel_o  = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/mem_store_wbuf.sv
// MEM-stage store write buffer: decodes stores, queues them
// in a small FIFO and drains them to data RAM via req/ack.
module mem_store_wbuf
   import mem_store_wbuf_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall,
   input  logic [7:0]  align_op_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] reg_i,
   input  logic [31:0] except_i,
   input  logic        LL_bit_i,
   output logic        ades_o,
   output logic [31:0] sc_result_o,
   output logic        stall_req_o,
   output logic        dbus_req_o,
   output logic [31:0] dbus_addr_o,
   output logic [3:0]  dbus_sel_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_ack_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wbuf_entry_t   buf_q [DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          req_q, req_d;
   wbuf_entry_t   out_q, out_d;

   logic [3:0]    dec_sel;
   logic [31:0]   dec_data;
   logic          dec_ades;
   logic          st_op, ld_op, sc_op;
   logic          full, hit, push, pop;
   logic [PW-1:0] off [DEPTH];

   store_lane_dec u_dec (
      .op_i   (align_op_i),
      .a_i    (mem_addr_i[1:0]),
      .reg_i  (reg_i),
      .sel_o  (dec_sel),
      .data_o (dec_data),
      .ades_o (dec_ades)
   );

   assign st_op = (store_kind(align_op_i) != ST_NONE);
   assign ld_op = is_load(align_op_i);
   assign sc_op = (align_op_i == EXE_SC_OP);
   assign full  = (count_q == CW'(DEPTH));

   // load hazard: word address matches any occupied slot
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         off[i] = PW'(i) - head_q;
         if (({1'b0, off[i]} < count_q) &&
             (buf_q[i].waddr == mem_addr_i[31:2]))
            hit = 1'b1;
      end
   end

   assign stall_req_o = (st_op & full) | (ld_op & hit);
   assign ades_o      = dec_ades;
   assign sc_result_o = {31'b0, sc_op & LL_bit_i};

   assign push = st_op & (except_i == 32'h0) & ~dec_ades & ~flush
               & (stall == NOSTOP) & ~stall_req_o
               & ~(sc_op & ~LL_bit_i);
   assign pop  = req_q & dbus_ack_i;

   assign dbus_req_o   = req_q;
   assign dbus_addr_o  = {out_q.waddr, 2'b00};
   assign dbus_sel_o   = out_q.sel;
   assign dbus_wdata_o = out_q.data;

   // pointer/occupancy update and bus presentation of the head entry
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      req_d   = req_q;
      out_d   = out_q;
      if (push)
         tail_d = tail_q + 1'b1;
      if (pop) begin
         head_d = head_q + 1'b1;
         req_d  = 1'b0;
      end else if (!req_q && (count_q != '0)) begin
         req_d = 1'b1;
         out_d = buf_q[head_q];
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // entry storage, written at the tail on accept
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            buf_q[i] <= '0;
      end else if (push) begin
         buf_q[tail_q] <= '{waddr: mem_addr_i[31:2],
                            sel:   dec_sel,
                            data:  dec_data};
      end
   end

   // pointer, count and registered bus payload state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         req_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         req_q   <= req_d;
         out_q   <= out_d;
      end
   end

endmodule

// File: tb/tb_mem_store_wbuf.sv
// Bench for mem_store_wbuf: directed cases plus random traffic
// against a byte-lane reference model and an expected-write queue.
module tb_mem_store_wbuf;
   import mem_store_wbuf_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic [7:0]  align_op_i = 8'h00;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] reg_i = '0;
   logic [31:0] except_i = '0;
   logic        LL_bit_i = 1'b0;
   logic        ades_o;
   logic [31:0] sc_result_o;
   logic        stall_req_o;
   logic        dbus_req_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_sel_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_ack_i = 1'b0;

   mem_store_wbuf #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .stall        (stall),
      .align_op_i   (align_op_i),
      .mem_addr_i   (mem_addr_i),
      .reg_i        (reg_i),
      .except_i     (except_i),
      .LL_bit_i     (LL_bit_i),
      .ades_o       (ades_o),
      .sc_result_o  (sc_result_o),
      .stall_req_o  (stall_req_o),
      .dbus_req_o   (dbus_req_o),
      .dbus_addr_o  (dbus_addr_o),
      .dbus_sel_o   (dbus_sel_o),
      .dbus_wdata_o (dbus_wdata_o),
      .dbus_ack_i   (dbus_ack_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] waddr;
      logic [3:0]  sel;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic acc;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // memory view: lane k is the byte at address word+k, bits [31-8k -: 8]
   function automatic exp_t model(input logic [7:0] op,
                                  input logic [31:0] addr,
                                  input logic [31:0] r);
      exp_t       e;
      int         a;
      logic [7:0] b [4];
      a       = int'(addr[1:0]);
      e.waddr = addr[31:2];
      e.sel   = 4'b0000;
      e.data  = 32'h0;
      for (int k = 0; k < 4; k++) b[k] = r[31-8*k -: 8];
      case (op)
         EXE_SB_OP: begin
            e.sel[3-a] = 1'b1;
            e.data     = {4{r[7:0]}};
         end
         EXE_SH_OP: begin
            if (a == 0) e.sel = 4'b1100;
            if (a == 2) e.sel = 4'b0011;
            e.data = {2{r[15:0]}};
         end
         EXE_SW_OP, EXE_SC_OP: begin
            e.sel  = 4'b1111;
            e.data = r;
         end
         EXE_SWL_OP: begin
            for (int k = a; k < 4; k++) begin
               e.sel[3-k]          = 1'b1;
               e.data[31-8*k -: 8] = b[k-a];
            end
         end
         EXE_SWR_OP: begin
            for (int k = 0; k <= a; k++) begin
               e.sel[3-k]          = 1'b1;
               e.data[31-8*k -: 8] = b[3-a+k];
            end
         end
         default: e.sel = 4'b0000;
      endcase
      return e;
   endfunction

   task automatic cyc(input logic [7:0] op, input logic [31:0] addr,
                      input logic [31:0] r, input logic [31:0] exc,
                      input logic ll, input logic fl, input logic st,
                      input logic ack, output logic accepted);
      logic s_op, l_op, c_op, e_ades, e_stall, h;
      @(posedge clk);
      #1;
      align_op_i = op;
      mem_addr_i = addr;
      reg_i      = r;
      except_i   = exc;
      LL_bit_i   = ll;
      flush      = fl;
      stall      = st;
      dbus_ack_i = ack;
      #1;
      s_op = op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP,
                        EXE_SWL_OP, EXE_SWR_OP, EXE_SC_OP};
      l_op = op inside {EXE_LB_OP, EXE_LH_OP, EXE_LWL_OP, EXE_LW_OP,
                        EXE_LBU_OP, EXE_LHU_OP, EXE_LWR_OP, EXE_LL_OP};
      c_op = (op == EXE_SC_OP);
      e_ades = ((op == EXE_SH_OP) && addr[0]) ||
               (((op == EXE_SW_OP) || c_op) && (addr[1:0] != 2'b00));
      h = 1'b0;
      foreach (q[i]) if (q[i].waddr == addr[31:2]) h = 1'b1;
      e_stall = (s_op && (q.size() == DEPTH)) || (l_op && h);
      chk("ades", {31'b0, ades_o}, {31'b0, e_ades});
      chk("stall_req", {31'b0, stall_req_o}, {31'b0, e_stall});
      chk("sc_result", sc_result_o, {31'b0, c_op && ll});
      if (q.size() == 0) chk("req_idle", {31'b0, dbus_req_o}, 32'h0);
      accepted = s_op && (exc == 32'h0) && !e_ades && !fl &&
                 (st == NOSTOP) && !e_stall && !(c_op && !ll);
      if (accepted) q.push_back(model(op, addr, r));
   endtask

   task automatic idle(input logic ack);
      logic a;
      cyc(EXE_NOP_OP, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, NOSTOP, ack, a);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d writes left, expected 0", q.size());
      end
      idle(1'b0);
   endtask

   // monitor: a write retires on an edge where req and ack are both high
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && dbus_req_o && dbus_ack_i) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL dbus_extra: got write %h expected none",
                        dbus_addr_o);
            end else begin
               e = q.pop_front();
               chk("dbus_addr", dbus_addr_o, {e.waddr, 2'b00});
               chk("dbus_sel", {28'b0, dbus_sel_o}, {28'b0, e.sel});
               chk("dbus_wdata", dbus_wdata_o, e.data);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] ops [15] = '{EXE_NOP_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP,
                            EXE_SWL_OP, EXE_SWR_OP, EXE_SC_OP, EXE_LB_OP,
                            EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
                            EXE_LWL_OP, EXE_LWR_OP, EXE_LL_OP};

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req", {31'b0, dbus_req_o}, 32'h0);
      chk("rst_addr", dbus_addr_o, 32'h0);
      chk("rst_sel", {28'b0, dbus_sel_o}, 32'h0);
      chk("rst_wdata", dbus_wdata_o, 32'h0);
      chk("rst_stall", {31'b0, stall_req_o}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;

      cyc(EXE_SB_OP, 32'h103, 32'hAB, 0, 0, 0, NOSTOP, 0, acc);
      idle(1'b0);
      idle(1'b0);
      chk("sb_req", {31'b0, dbus_req_o}, 32'h1);
      chk("sb_addr", dbus_addr_o, 32'h100);
      chk("sb_sel", {28'b0, dbus_sel_o}, 32'h1);
      chk("sb_wdata", dbus_wdata_o, 32'hABABABAB);
      drain();

      cyc(EXE_SWL_OP, 32'h202, 32'h11223344, 0, 0, 0, NOSTOP, 0, acc);
      cyc(EXE_SWR_OP, 32'h202, 32'h11223344, 0, 0, 0, NOSTOP, 0, acc);
      drain();

      cyc(EXE_SH_OP, 32'h101, 32'h5555, 0, 0, 0, NOSTOP, 0, acc);
      chk("sh_ades", {31'b0, ades_o}, 32'h1);
      idle(1'b0);
      idle(1'b0);
      chk("sh_noreq", {31'b0, dbus_req_o}, 32'h0);

      cyc(EXE_SW_OP, 32'h500, 32'hA0, 0, 0, 0, NOSTOP, 0, acc);
      cyc(EXE_SW_OP, 32'h504, 32'hA1, 0, 0, 0, NOSTOP, 0, acc);
      cyc(EXE_SW_OP, 32'h508, 32'hA2, 0, 0, 0, NOSTOP, 0, acc);
      chk("full_stall", {31'b0, stall_req_o}, 32'h1);
      cyc(EXE_SW_OP, 32'h508, 32'hA2, 0, 0, 0, NOSTOP, 1, acc);
      cyc(EXE_SW_OP, 32'h508, 32'hA2, 0, 0, 0, NOSTOP, 0, acc);
      chk("third_go", {31'b0, stall_req_o}, 32'h0);
      drain();

      cyc(EXE_SW_OP, 32'h300, 32'hCAFE, 0, 0, 0, NOSTOP, 0, acc);
      cyc(EXE_LW_OP, 32'h302, 0, 0, 0, 0, NOSTOP, 0, acc);
      chk("ld_hit", {31'b0, stall_req_o}, 32'h1);
      cyc(EXE_LW_OP, 32'h304, 0, 0, 0, 0, NOSTOP, 0, acc);
      chk("ld_miss", {31'b0, stall_req_o}, 32'h0);
      cyc(EXE_LW_OP, 32'h302, 0, 0, 0, 0, NOSTOP, 1, acc);
      chk("ld_hit_ack", {31'b0, stall_req_o}, 32'h1);
      cyc(EXE_LW_OP, 32'h302, 0, 0, 0, 0, NOSTOP, 0, acc);
      chk("ld_release", {31'b0, stall_req_o}, 32'h0);
      drain();

      cyc(EXE_SC_OP, 32'h700, 32'h77, 0, 0, 0, NOSTOP, 0, acc);
      chk("sc_fail", sc_result_o, 32'h0);
      cyc(EXE_SC_OP, 32'h704, 32'h78, 0, 1, 0, NOSTOP, 0, acc);
      chk("sc_ok", sc_result_o, 32'h1);
      drain();

      cyc(EXE_SW_OP, 32'h600, 32'h66, 0, 0, 0, NOSTOP, 0, acc);
      idle(1'b0);
      idle(1'b0);
      chk("pre_rst_req", {31'b0, dbus_req_o}, 32'h1);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, dbus_req_o}, 32'h0);
      chk("mid_rst_sel", {28'b0, dbus_sel_o}, 32'h0);
      chk("mid_rst_wdata", dbus_wdata_o, 32'h0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      idle(1'b0);
      idle(1'b0);

      for (int n = 0; n < 600; n++) begin
         cyc(ops[$urandom_range(0, 14)],
             32'h400 + 32'($urandom_range(0, 31)),
             32'($urandom),
             ($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0),
             1'($urandom_range(0, 1)),
             acc);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
